// File: rtl/pi_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pi_link_pkg
//  Description : Shared types and constants for the Raspberry Pi -> FPGA
//                parallel byte link receive path.
//                - FSM state encoding (IDLE / ACK / ERR)
//                - byte width, timeout counter width, default FIFO depth
//  Revision    : 1.0 - initial release
// ============================================================================
package pi_link_pkg;

    localparam int PI_LINK_BYTE_W     = 8;
    localparam int PI_LINK_TMO_W      = 16;
    localparam int PI_LINK_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_ERR  = 2'd2
    } pi_link_state_e;

endpackage : pi_link_pkg
`default_nettype wire

// File: rtl/pi_link_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pi_link_fifo
//  Description : First-word fall-through FIFO. The head entry is presented on
//                pop_data whenever the FIFO is non-empty. Pointers wrap
//                modulo DEPTH (DEPTH must be a power of 2, >= 2).
//  Ports       : clk, reset       - clock, async active-high reset
//                push, push_data  - write request / data (ignored when full)
//                pop              - remove head entry (ignored when empty)
//                pop_data         - head entry (0 after reset)
//                full, empty      - occupancy flags
//                level            - occupancy count, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module pi_link_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop  && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Simultaneous push and pop leaves the level unchanged.
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule : pi_link_fifo
`default_nettype wire

// File: rtl/pi_link_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pi_link_rx_ctrl
//  Description : Receive controller for the Raspberry Pi -> FPGA parallel
//                byte link. Runs a 4-phase request/acknowledge handshake,
//                captures one byte per handshake into a FWFT FIFO and
//                throttles the Pi by withholding acknowledge while full.
//  Ports       : clk, reset            - clock, async active-high reset
//                pi_hsk_raw            - Pi request (asynchronous)
//                pi_data[7:0]          - Pi data bus (sampled on accept)
//                fpga_hsk              - registered acknowledge to the Pi
//                rx_data, rx_valid     - FIFO head / not-empty
//                rx_ready              - consumer accepts head
//                fifo_level            - FIFO occupancy
//                timeout_err           - sticky abort flag
//                clear_err             - clears timeout_err
//  Options     : PI_LINK_TIMEOUT_EN - when defined, a transfer held in ACK
//                for TIMEOUT_CYCLES cycles is aborted into ERR and
//                timeout_err is set. Undefined: ACK waits indefinitely.
//  Revision    : 1.0 - initial release
// ============================================================================
module pi_link_rx_ctrl
    import pi_link_pkg::*;
#(
    parameter int FIFO_DEPTH     = PI_LINK_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pi_hsk_raw,
    input  logic [PI_LINK_BYTE_W-1:0]   pi_data,
    output logic                        fpga_hsk,
    output logic [PI_LINK_BYTE_W-1:0]   rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        timeout_err,
    input  logic                        clear_err
);

    // Terminal count: the ACK cycle in which the counter holds this value is
    // the TIMEOUT_CYCLES-th consecutive ACK cycle.
    localparam logic [PI_LINK_TMO_W-1:0] TMO_LAST = PI_LINK_TMO_W'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Request synchronizer (2 flops). pi_data is deliberately not
    // synchronized: the Pi holds it stable for the whole request phase.
    // ------------------------------------------------------------------
    logic req_meta_q;
    logic req_s_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
        end else begin
            req_meta_q <= pi_hsk_raw;
            req_s_q    <= req_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;

    assign rx_valid = !fifo_empty;
    assign fifo_pop = rx_valid && rx_ready;

    pi_link_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PI_LINK_BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (pi_data),
        .pop       (fifo_pop),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    pi_link_state_e state_q, state_d;
    logic           fpga_hsk_q, fpga_hsk_d;

`ifdef PI_LINK_TIMEOUT_EN
    logic [PI_LINK_TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                     tmo_set;
    logic                     timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d   = state_q;
        fifo_push = 1'b0;
`ifdef PI_LINK_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        tmo_set   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                // Full FIFO: stay here without acking so the Pi stalls.
                // Fullness comes from the registered level, so a pop in
                // this same cycle only frees space for the next cycle.
                if (req_s_q && !fifo_full) begin
                    fifo_push = 1'b1;
                    state_d   = ST_ACK;
`ifdef PI_LINK_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end

            ST_ACK: begin
                if (!req_s_q) begin
                    state_d = ST_IDLE;
                end
`ifdef PI_LINK_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_ERR;
                    tmo_set = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

`ifdef PI_LINK_TIMEOUT_EN
            ST_ERR: begin
                // Acknowledge already dropped; wait for the Pi to give up.
                if (!req_s_q) begin
                    state_d = ST_IDLE;
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase

        // Acknowledge is a dedicated flop so the Pi sees a glitch-free level.
        fpga_hsk_d = (state_d == ST_ACK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fpga_hsk_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fpga_hsk_q <= fpga_hsk_d;
        end
    end

    assign fpga_hsk = fpga_hsk_q;

    // ------------------------------------------------------------------
    // Timeout counter and sticky error flag
    // ------------------------------------------------------------------
`ifdef PI_LINK_TIMEOUT_EN
    always_comb begin
        timeout_err_d = timeout_err_q;
        if (clear_err) begin
            timeout_err_d = 1'b0;
        end
        // A new timeout in the same cycle as a clear wins.
        if (tmo_set) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic [1:0] unused_cfg;
    assign unused_cfg  = {clear_err, TMO_LAST[0]};
    assign timeout_err = 1'b0;
`endif

endmodule : pi_link_rx_ctrl
`default_nettype wire

// File: tb/tb_pi_link_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pi_link_rx_ctrl
//  Description : Self-checking bench for pi_link_rx_ctrl. A queue-based
//                scoreboard tracks the bytes the Pi has had acknowledged and
//                the consumer has taken, and predicts rx_valid, rx_data and
//                fifo_level every cycle. Directed scenarios check handshake
//                latency, backpressure, streaming, reset mid-transfer and
//                (with PI_LINK_TIMEOUT_EN) the abort path; a random phase
//                mixes Pi traffic with a random consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pi_link_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic       clk;
    logic       reset;
    logic       pi_hsk_raw;
    logic [7:0] pi_data;
    logic       fpga_hsk;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] fifo_level;
    logic       timeout_err;
    logic       clear_err;

    logic       rand_en;
    logic       rand_bit;
    logic       ready_cmd;

    int         n_checks;
    int         n_fail;

    pi_link_rx_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pi_hsk_raw  (pi_hsk_raw),
        .pi_data     (pi_data),
        .fpga_hsk    (fpga_hsk),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .fifo_level  (fifo_level),
        .timeout_err (timeout_err),
        .clear_err   (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rx_ready = rand_en ? rand_bit : ready_cmd;

    always @(posedge clk) begin
        #2;
        rand_bit = ($urandom_range(0, 1) == 1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: a byte enters when the Pi sees acknowledge rise, leaves
    // when the consumer takes it. Checked once per cycle on the negedge.
    // ------------------------------------------------------------------
    logic [7:0] exp_q[$];
    bit         pop_pend;
    bit         hsk_prev;
    int         max_lvl;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            pop_pend = 1'b0;
            hsk_prev = 1'b0;
        end else begin
            if (pop_pend && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
            if (fpga_hsk && !hsk_prev) begin
                exp_q.push_back(pi_data);
            end
            hsk_prev = fpga_hsk;
            check("sb_level", 32'(fifo_level), 32'(exp_q.size()));
            check("sb_valid", 32'(rx_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("sb_data", 32'(rx_data), 32'(exp_q[0]));
            end
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            pop_pend = rx_valid && rx_ready;
        end
    end

    // ------------------------------------------------------------------
    // Pi-side helpers. exp_lat < 0 means "any latency within the bound".
    // ------------------------------------------------------------------
    task automatic pi_raise(input logic [7:0] d, input int exp_lat, input string tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        pi_data    = d;
        pi_hsk_raw = 1'b1;
        while (n < 300) begin
            @(posedge clk); #1;
            n++;
            if (fpga_hsk) break;
        end
        if (!fpga_hsk)        check({tag, "_ack_timeout"}, 32'(fpga_hsk), 32'd1);
        else if (exp_lat >= 0) check({tag, "_rise_lat"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic pi_drop(input int exp_lat, input string tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        pi_hsk_raw = 1'b0;
        while (n < 300) begin
            @(posedge clk); #1;
            n++;
            if (!fpga_hsk) break;
        end
        if (fpga_hsk)          check({tag, "_fall_timeout"}, 32'(fpga_hsk), 32'd0);
        else if (exp_lat >= 0) check({tag, "_fall_lat"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        ready_cmd = 1'b1;
        while (n < 100 && fifo_level != 0) begin
            @(posedge clk); #1;
            n++;
        end
        ready_cmd = 1'b0;
        check({tag, "_drained"}, 32'(fifo_level), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks   = 0;
        n_fail     = 0;
        max_lvl    = 0;
        rand_en    = 1'b0;
        ready_cmd  = 1'b0;
        pi_hsk_raw = 1'b0;
        pi_data    = 8'h00;
        clear_err  = 1'b0;
        reset      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hsk",   32'(fpga_hsk),    32'd0);
        check("rst_valid", 32'(rx_valid),    32'd0);
        check("rst_data",  32'(rx_data),     32'd0);
        check("rst_level", 32'(fifo_level),  32'd0);
        check("rst_err",   32'(timeout_err), 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;

        // ---- single byte ----
        pi_raise(8'hA5, 3, "single");
        check("single_valid", 32'(rx_valid),   32'd1);
        check("single_data",  32'(rx_data),    32'hA5);
        check("single_level", 32'(fifo_level), 32'd1);
        pi_drop(3, "single");
        drain("single");

        // ---- backpressure ----
        for (int i = 1; i <= 4; i++) begin
            pi_raise(8'(i), 3, "bp");
            pi_drop(3, "bp");
        end
        check("bp_full_level", 32'(fifo_level), 32'd4);
        @(posedge clk); #1;
        pi_data    = 8'h05;
        pi_hsk_raw = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("bp_no_ack_full", 32'(fpga_hsk), 32'd0);
        ready_cmd = 1'b1;
        @(posedge clk); #1;
        ready_cmd = 1'b0;
        n = 0;
        while (n < 10 && !fpga_hsk) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_ack_after_pop", 32'(n), 32'd1);
        check("bp_head",  32'(rx_data),    32'h02);
        check("bp_level", 32'(fifo_level), 32'd4);
        pi_drop(3, "bp5");
        drain("bp");

        // ---- streaming with push/pop overlap ----
        @(posedge clk); #1;
        ready_cmd = 1'b1;
        max_lvl   = 0;
        for (int i = 16; i < 32; i++) begin
            pi_raise(8'(i), 3, "stream");
            pi_drop(3, "stream");
        end
        repeat (3) @(posedge clk);
        #1;
        check("stream_max_lvl", 32'(max_lvl <= 1), 32'd1);
        check("stream_empty",   32'(fifo_level),   32'd0);
        ready_cmd = 1'b0;

`ifdef PI_LINK_TIMEOUT_EN
        // ---- timeout abort ----
        pi_raise(8'h3C, 3, "tmo");
        n = 0;
        while (n < 100 && fpga_hsk) begin
            @(posedge clk); #1;
            n++;
        end
        check("tmo_ack_cycles", 32'(n), 32'(TMO));
        check("tmo_err_set", 32'(timeout_err), 32'd1);
        check("tmo_byte_kept", 32'(rx_data), 32'h3C);
        pi_hsk_raw = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("tmo_err_sticky", 32'(timeout_err), 32'd1);
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        check("tmo_err_clear", 32'(timeout_err), 32'd0);
        pi_raise(8'h3D, 3, "tmo_idle");
        pi_drop(3, "tmo_idle");
        drain("tmo");
`endif

        // ---- reset mid-transfer ----
        pi_raise(8'h77, 3, "rstmid");
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("rstmid_hsk",   32'(fpga_hsk),   32'd0);
        check("rstmid_level", 32'(fifo_level), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        n = 0;
        while (n < 20 && !fpga_hsk) begin
            @(posedge clk); #1;
            n++;
        end
        check("rstmid_reaccept_lat", 32'(n), 32'd3);
        check("rstmid_data",  32'(rx_data),    32'h77);
        check("rstmid_level2", 32'(fifo_level), 32'd1);
        pi_drop(3, "rstmid");
        drain("rstmid");

        // ---- random traffic against a random consumer ----
        rand_en = 1'b1;
        for (int i = 0; i < 48; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            pi_raise(8'($urandom_range(0, 255)), -1, "rand");
            pi_drop(3, "rand");
        end
        rand_en = 1'b0;
        drain("rand");
        check("final_err", 32'(timeout_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pi_link_rx_ctrl
`default_nettype wire

// File: doc/pi_link_rx_ctrl.md
# pi_link_rx_ctrl

Receive-side controller for the Raspberry Pi → FPGA parallel byte link. It sequences a full 4-phase request/acknowledge handshake on `pi_hsk_raw`/`fpga_hsk` and captures each byte from the 8-bit bus. Captured bytes go into a small FIFO that fabric logic drains through a valid/ready port. It sits between the Pi GPIO pins and the first fabric consumer. It throttles the Pi by withholding acknowledge while the FIFO is full.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: FIFO entries. Must be a power of 2 and ≥ 2.
- `TIMEOUT_CYCLES`, default 65535: maximum cycles in ACK before abort. Range 1..65535. Used only with `PI_LINK_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: the single system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `pi_hsk_raw`, in, 1: Pi request. Asynchronous to `clk`.
- `pi_data`, in, 8: Pi data bus. The Pi holds it stable from before request rise until it sees `fpga_hsk` high.
- `fpga_hsk`, out, 1: acknowledge to the Pi. Registered.
- `rx_data`, out, 8: FIFO head byte.
- `rx_valid`, out, 1: FIFO not empty.
- `rx_ready`, in, 1: consumer accepts `rx_data`.
- `fifo_level`, out, clog2(FIFO_DEPTH)+1: current occupancy.
- `timeout_err`, out, 1: sticky abort flag.
- `clear_err`, in, 1: clears `timeout_err`.

## Operation
Request synchronization:
- `pi_hsk_raw` passes through a 2-flop synchronizer to produce `req_s`.
- `pi_data` is not synchronized. It is sampled only in the cycle the request is accepted.

FSM states and transitions:
- **IDLE** (`fpga_hsk`=0):
  - If `req_s`=1 and FIFO not full: push `pi_data`, go to ACK.
  - If `req_s`=1 and FIFO full: stay in IDLE. The Pi stalls; nothing is dropped.
- **ACK** (`fpga_hsk`=1): wait for `req_s`=0, then go to IDLE. Leaving ACK drops `fpga_hsk`, completing the 4-phase cycle.
- **ERR** (`fpga_hsk`=0): exists only with the macro. Wait for `req_s`=0, then go to IDLE.

FIFO:
- First-word fall-through.
- `rx_valid` = !empty.
- Pop on `rx_valid && rx_ready`.
- Read/write pointers wrap modulo `FIFO_DEPTH`.

FIFO boundary conditions:
- Push and pop in the same cycle: level unchanged, and both operations take effect.
- When full, a pop in the same cycle as an IDLE request does not enable the push. The push occurs the next cycle.
- Pop while empty is ignored.

Reset:
- Async assert sets: state=IDLE, `fpga_hsk`=0, `rx_valid`=0, `rx_data`=0, `fifo_level`=0, `timeout_err`=0, synchronizer flops=0.
- Reset mid-transfer: `fpga_hsk` drops immediately. If the Pi still holds its request after reset release, the byte is accepted again as new data. Duplicate handling belongs to Pi software.

## Timing
- `pi_hsk_raw` rise → `fpga_hsk` rise: 3 clk when the FIFO has space (2 synchronizer cycles + 1 registered FSM).
- `pi_hsk_raw` fall → `fpga_hsk` fall: 3 clk.
- Push into an empty FIFO → `rx_valid`=1 on the next cycle, with `rx_data` valid in that cycle.
- One byte per handshake, at most one byte per 6 clk.
- `fifo_level` updates the cycle after a push or pop.

## Configuration
`PI_LINK_TIMEOUT_EN`:
- **Defined:**
  - A 16-bit counter clears on entry to ACK and increments every ACK cycle.
  - When it reaches `TIMEOUT_CYCLES` with `req_s` still 1, the FSM goes to ERR and `timeout_err` sets.
  - `timeout_err` stays set until `clear_err`=1. If `clear_err` and a new timeout occur in the same cycle, set wins.
  - The byte already pushed is kept.
- **Undefined:**
  - No counter and no ERR state; ACK waits indefinitely.
  - `timeout_err` is tied to 0 and `clear_err` is ignored.

## Structure
- `pi_link_pkg` holds:
  - the FSM state enum (IDLE/ACK/ERR);
  - the default `FIFO_DEPTH`;
  - the timeout counter width (16);
  - the byte width (8).
- One sub-module, `pi_link_fifo`: parameterized FWFT FIFO with `push`, `pop`, `full`, `empty`, `level`.
- The FSM and synchronizer live in the top module.

## Test plan
- **Single byte.** Pi drives 0xA5, raises request, waits for ack, drops request. Required: `fpga_hsk` rises 3 clk after request and falls 3 clk after request drop. `rx_data`=0xA5 with `rx_valid`=1. `fifo_level`=1.
- **Backpressure.** `rx_ready`=0, `FIFO_DEPTH`=4, send 0x01..0x05. Required: 4 bytes acked and the 5th request gets no ack. Then pulse `rx_ready` for one cycle. Required: 0x01 pops, 0x05 is then acked, and the FIFO holds 0x02..0x05.
- **Simultaneous push/pop.** `rx_ready`=1 continuously, streaming 0x10..0x1F. Required: all 16 bytes arrive in order, `fifo_level` never exceeds 1, no ack is missed.
- **Timeout** (macro on, `TIMEOUT_CYCLES`=20). Hold request high after ack. Required: `fpga_hsk` falls and `timeout_err`=1 after 20 ACK cycles. Drop request. Required: return to IDLE. `clear_err` → `timeout_err`=0.
- **Reset mid-transfer.** Assert `reset` during ACK. Required: `fpga_hsk`=0 and `fifo_level`=0 immediately. Request still high at release. Required: the same byte is re-accepted after 3 clk.
